// File: rtl/cardinal_dmem.sv
// Word-addressed 64-bit data memory with a fixed WAIT_STATES+1 cycle request-to-response latency.
// One request in flight at a time; Mem_En is ignored while Mem_Busy is high.
module cardinal_dmem #(
    parameter int WAIT_STATES = 1,
    parameter int DEPTH       = 256
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Mem_En,
    input  logic        Mem_Wr_En,
    input  logic [0:7]  Mem_Addr,
    input  logic [0:63] Data_In,
    output logic [0:63] Data_Out,
    output logic        Mem_Ready,
    output logic        Mem_Busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic [0:7]  cap_addr;
    logic        cap_wr;
    logic [0:63] cap_data;
    logic [0:63] mem [0:DEPTH-1];

    logic        accept;
    logic        commit;
    logic        in_range;
    logic [0:7]  req_addr;
    logic        req_wr;
    logic [0:63] req_data;
    logic [AW-1:0] idx;

    // With zero wait states the commit happens on the acceptance edge itself,
    // before the capture registers hold the request, so use the live inputs then.
    assign accept   = (state == IDLE) && Mem_En;
    assign req_addr = (state == IDLE) ? Mem_Addr  : cap_addr;
    assign req_wr   = (state == IDLE) ? Mem_Wr_En : cap_wr;
    assign req_data = (state == IDLE) ? Data_In   : cap_data;
    assign in_range = {1'b0, req_addr} < 9'(DEPTH);
    assign idx      = req_addr[8-AW:7];
    assign commit   = !Reset && (state != RESP) && (state_next == RESP);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (Mem_En) begin
                    state_next = (WAIT_STATES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        Mem_Ready = (state == RESP);
        Mem_Busy  = (state != IDLE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt      <= 4'd0;
            cap_addr <= '0;
            cap_wr   <= 1'b0;
            cap_data <= '0;
        end else if (accept) begin
            cnt      <= CNT_INIT;
            cap_addr <= Mem_Addr;
            cap_wr   <= Mem_Wr_En;
            cap_data <= Data_In;
        end else if ((state == WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Storage is deliberately left out of reset so contents survive it.
    always_ff @(posedge Clock) begin
        if (commit && req_wr && in_range) begin
            mem[idx] <= req_data;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Data_Out <= '0;
        end else if (commit && !req_wr) begin
            Data_Out <= in_range ? mem[idx] : '0;
        end
    end

endmodule

// File: tb/tb_cardinal_dmem.sv
// Bench for cardinal_dmem: four instances (varied WAIT_STATES/DEPTH) on shared stimulus,
// each checked every cycle against a latency-based reference model, plus directed vectors.
module tb_cardinal_dmem;

    localparam int NDUT = 4;
    localparam int WS [NDUT] = '{1, 0, 3, 1};
    localparam int DP [NDUT] = '{256, 256, 256, 128};

    logic        clk;
    logic        rst;
    logic        en;
    logic        wr;
    logic [0:7]  addr;
    logic [0:63] din;
    logic [0:63] dout [NDUT];
    logic        rdy  [NDUT];
    logic        bsy  [NDUT];

    int n_vec;
    int n_miss;

    // Reference model: phase = edges since acceptance (-1 when idle).
    int          ph  [NDUT];
    logic [63:0] mm  [NDUT][256];
    logic [63:0] md  [NDUT];
    logic        cw  [NDUT];
    logic [7:0]  ca  [NDUT];
    logic [63:0] cd  [NDUT];

    cardinal_dmem #(.WAIT_STATES(1), .DEPTH(256)) u_d0 (
        .Clock(clk), .Reset(rst), .Mem_En(en), .Mem_Wr_En(wr), .Mem_Addr(addr),
        .Data_In(din), .Data_Out(dout[0]), .Mem_Ready(rdy[0]), .Mem_Busy(bsy[0]));
    cardinal_dmem #(.WAIT_STATES(0), .DEPTH(256)) u_d1 (
        .Clock(clk), .Reset(rst), .Mem_En(en), .Mem_Wr_En(wr), .Mem_Addr(addr),
        .Data_In(din), .Data_Out(dout[1]), .Mem_Ready(rdy[1]), .Mem_Busy(bsy[1]));
    cardinal_dmem #(.WAIT_STATES(3), .DEPTH(256)) u_d2 (
        .Clock(clk), .Reset(rst), .Mem_En(en), .Mem_Wr_En(wr), .Mem_Addr(addr),
        .Data_In(din), .Data_Out(dout[2]), .Mem_Ready(rdy[2]), .Mem_Busy(bsy[2]));
    cardinal_dmem #(.WAIT_STATES(1), .DEPTH(128)) u_d3 (
        .Clock(clk), .Reset(rst), .Mem_En(en), .Mem_Wr_En(wr), .Mem_Addr(addr),
        .Data_In(din), .Data_Out(dout[3]), .Mem_Ready(rdy[3]), .Mem_Busy(bsy[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] init_word(input logic [7:0] a);
        return {8'h5A, a, 48'h0123_4567_89AB};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic commit_req(input int k);
        if (cw[k]) begin
            if (int'(ca[k]) < DP[k]) mm[k][ca[k]] = cd[k];
        end else begin
            md[k] = (int'(ca[k]) < DP[k]) ? mm[k][ca[k]] : 64'h0;
        end
    endtask

    task automatic model_edge(input int k, input logic r, input logic e, input logic w,
                              input logic [7:0] a, input logic [63:0] d);
        if (r) begin
            ph[k] = -1;
            md[k] = 64'h0;
        end else if (ph[k] < 0) begin
            if (e) begin
                cw[k] = w; ca[k] = a; cd[k] = d; ph[k] = 0;
                if (WS[k] == 0) commit_req(k);
            end
        end else begin
            ph[k]++;
            if (ph[k] > WS[k]) ph[k] = -1;
            else if (ph[k] == WS[k]) commit_req(k);
        end
    endtask

    // Drive one cycle of inputs (called at a negedge), then compare every instance.
    task automatic step(input logic r, input logic e, input logic w,
                        input logic [7:0] a, input logic [63:0] d);
        rst = r; en = e; wr = w; addr = a; din = d;
        @(posedge clk);
        for (int k = 0; k < NDUT; k++) model_edge(k, r, e, w, a, d);
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("d%0d ready", k), 64'(rdy[k]), 64'(ph[k] == WS[k]));
            check($sformatf("d%0d busy", k), 64'(bsy[k]), 64'(ph[k] >= 0));
            check($sformatf("d%0d dout", k), dout[k], md[k]);
        end
    endtask

    function automatic bit any_busy();
        for (int k = 0; k < NDUT; k++) if (ph[k] >= 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_idle();
        for (int i = 0; i < 20 && any_busy(); i++) step(0, 0, 0, 8'h00, 64'h0);
        if (any_busy()) begin
            n_vec++;
            n_miss++;
            $display("FAIL idle timeout @%0t", $time);
        end
    endtask

    typedef struct {
        logic        e;
        logic        w;
        logic [7:0]  a;
        logic [63:0] d;
        logic        x_rdy;
        logic        x_bsy;
        logic [63:0] x_dout;
    } vec_t;

    vec_t tbl [9];

    initial begin
        n_vec = 0;
        n_miss = 0;
        rst = 1'b1; en = 1'b0; wr = 1'b0; addr = '0; din = '0;
        for (int k = 0; k < NDUT; k++) begin
            ph[k] = -1; md[k] = 64'h0; cw[k] = 1'b0; ca[k] = '0; cd[k] = '0;
        end

        // Expected outputs of the WAIT_STATES=1 instance for the write/read walk.
        tbl[0] = '{1'b1, 1'b1, 8'h05, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b1, 64'h0};
        tbl[1] = '{1'b1, 1'b1, 8'h05, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 64'h0};
        tbl[2] = '{1'b0, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 64'h0};
        tbl[3] = '{1'b1, 1'b0, 8'h05, 64'h0, 1'b0, 1'b1, 64'h0};
        tbl[4] = '{1'b0, 1'b1, 8'h06, 64'h1, 1'b1, 1'b1, 64'hDEAD_BEEF_0123_4567};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 64'hDEAD_BEEF_0123_4567};
        tbl[6] = '{1'b1, 1'b0, 8'h06, 64'h0, 1'b0, 1'b1, 64'hDEAD_BEEF_0123_4567};
        tbl[7] = '{1'b0, 1'b0, 8'h00, 64'h0, 1'b1, 1'b1, init_word(8'h06)};
        tbl[8] = '{1'b0, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, init_word(8'h06)};

        @(negedge clk);
        step(1, 1, 1, 8'h00, 64'h0);
        step(1, 0, 0, 8'h00, 64'h0);

        for (int a = 0; a < 256; a++) begin
            step(0, 1, 1, 8'(a), init_word(8'(a)));
            wait_idle();
        end

        for (int i = 0; i < 9; i++) begin
            step(0, tbl[i].e, tbl[i].w, tbl[i].a, tbl[i].d);
            check($sformatf("tbl%0d ready", i), 64'(rdy[0]), 64'(tbl[i].x_rdy));
            check($sformatf("tbl%0d busy", i), 64'(bsy[0]), 64'(tbl[i].x_bsy));
            check($sformatf("tbl%0d dout", i), dout[0], tbl[i].x_dout);
        end

        // Zero wait states with Mem_En held: accept, ignore, accept, ...
        wait_idle();
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0, 8'(i), 64'h0);
            check($sformatf("ws0 b2b ready%0d", i), 64'(rdy[1]), 64'(i % 2 == 0));
        end

        // Reset in the second wait cycle of the WAIT_STATES=3 instance drops the write.
        wait_idle();
        step(0, 1, 1, 8'hFF, 64'h1);
        step(0, 0, 0, 8'h00, 64'h0);
        step(1, 0, 0, 8'h00, 64'h0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 8'h00, 64'h0);
            check("ws3 abort ready", 64'(rdy[2]), 64'h0);
        end
        step(0, 1, 0, 8'hFF, 64'h0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 64'h0);
        check("ws3 abort rd ready", 64'(rdy[2]), 64'h1);
        check("ws3 abort rd data", dout[2], init_word(8'hFF));

        // Array survives a reset pulse; Data_Out is 0 until the read response.
        wait_idle();
        step(0, 1, 1, 8'h10, 64'hAAAA_AAAA_AAAA_AAAA);
        wait_idle();
        step(1, 0, 0, 8'h00, 64'h0);
        check("rst dout", dout[0], 64'h0);
        step(0, 1, 0, 8'h10, 64'h0);
        check("rst pre-resp dout", dout[0], 64'h0);
        step(0, 0, 0, 8'h00, 64'h0);
        check("rst keep ready", 64'(rdy[0]), 64'h1);
        check("rst keep data", dout[0], 64'hAAAA_AAAA_AAAA_AAAA);

        // Out-of-range address on the DEPTH=128 instance.
        wait_idle();
        step(0, 1, 1, 8'h80, 64'hC3C3_0000_1111_2222);
        wait_idle();
        step(0, 1, 0, 8'h80, 64'h0);
        step(0, 0, 0, 8'h00, 64'h0);
        check("oor ready", 64'(rdy[3]), 64'h1);
        check("oor data", dout[3], 64'h0);
        check("inrange data", dout[0], 64'hC3C3_0000_1111_2222);

        wait_idle();
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 {$urandom, $urandom});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
